// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel output stage.
package vga_pkg;

    localparam int RGB_W_DEFAULT = 12;

    // Frame alignment states of the pixel stream
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [RGB_W_DEFAULT-1:0] BLACK = '0;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Small synchronous FIFO with occupancy output and a peek at the head entry.
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int W     = 13,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    // Guard against overflow and popping an empty FIFO regardless of the caller
    assign do_push = push_i && (level_q < FULL);
    assign do_pop  = pop_i && (level_q != '0);

    // Pointer and level update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless while level is zero, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/vga_pixel_stream.sv
// Last stage before the DAC: buffers the upstream pixel stream, aligns it to the
// beam using the start-of-frame marker, and registers RGB and syncs together.
module vga_pixel_stream
    import vga_pkg::*;
#(
    parameter int RGB_W      = RGB_W_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 display_on,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [RGB_W-1:0]     s_data,
    input  logic                 s_sof,
    output logic [RGB_W-1:0]     vga_rgb,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] underflow_cnt,
    output logic                 sof_err
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]    FULL  = LW'(FIFO_DEPTH);
    localparam logic [RGB_W-1:0] BLANK = RGB_W'(BLACK);

    state_t                 state_q, state_d;
    logic [RGB_W-1:0]       rgb_q, rgb_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   hsync_q, vsync_q, locked_q;

    logic [LW-1:0]          level;
    logic [RGB_W:0]         head;
    logic                   head_sof;
    logic [RGB_W-1:0]       head_data;
    logic                   push, pop, fifo_empty, frame_start;

    assign s_ready     = !reset && (level < FULL);
    assign push        = s_valid && s_ready;
    assign head_sof    = head[RGB_W];
    assign head_data   = head[RGB_W-1:0];
    assign fifo_empty  = (level == '0);
    assign frame_start = display_on && (hpos == '0) && (vpos == '0);

    vga_pixel_fifo #(
        .W     (RGB_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .wr_data_i ({s_sof, s_data}),
        .pop_i     (pop),
        .head_o    (head),
        .level_o   (level)
    );

    // Alignment decisions: which entry leaves the FIFO and what colour is shown next
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        rgb_d   = BLANK;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            HUNT: begin
                if (!fifo_empty) begin
                    if (head_sof) state_d = ARMED;
                    else          pop     = 1'b1;
                end
            end
            ARMED: begin
                if (frame_start && !fifo_empty) begin
                    pop     = 1'b1;
                    rgb_d   = head_data;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (display_on) begin
                    if (fifo_empty) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
                    end else if (head_sof && !frame_start) begin
                        // Stream ended early: the held sof entry starts the next frame
                        err_d   = 1'b1;
                        state_d = ARMED;
                    end else if (frame_start && !head_sof) begin
                        // Stream ran long: discard the excess while hunting
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        pop   = 1'b1;
                        rgb_d = head_data;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // State and all outputs registered together so RGB and syncs share one cycle of lag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            rgb_q    <= BLANK;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync;
            vsync_q  <= vsync;
            locked_q <= (state_d == RUN);
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign vga_rgb       = rgb_q;
    assign vga_hsync     = hsync_q;
    assign vga_vsync     = vsync_q;
    assign locked        = locked_q;
    assign underflow_cnt = cnt_q;
    assign sof_err       = err_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Bench for vga_pixel_stream using a reduced raster (8x4 visible, 12x6 total).
module tb_vga_pixel_stream;

    localparam int DEPTH = 16;
    localparam int H_VIS = 8;
    localparam int H_TOT = 12;
    localparam int V_VIS = 4;
    localparam int V_TOT = 6;

    localparam int M_SEEK = 0;
    localparam int M_WAIT = 1;
    localparam int M_PLAY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = 10'd4;
    logic        display_on = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic [11:0] vga_rgb;
    logic        vga_hsync, vga_vsync, locked, sof_err;
    logic [15:0] underflow_cnt;

    vga_pixel_stream dut (
        .clk           (clk),
        .reset         (reset),
        .hpos          (hpos),
        .vpos          (vpos),
        .display_on    (display_on),
        .hsync         (hsync),
        .vsync         (vsync),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .vga_rgb       (vga_rgb),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .locked        (locked),
        .underflow_cnt (underflow_cnt),
        .sof_err       (sof_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus source: stimulus appends entries, driver advances the read index
    logic [12:0] src_q[$];
    int          src_rd = 0;
    bit          src_en = 1'b1;
    bit          raster_en = 1'b0;
    int          h = 0;
    int          v = 4;
    bit          acc_last = 1'b0;
    logic [12:0] cur;

    // Raster and pixel source advance on the falling edge
    always @(negedge clk) begin
        if (raster_en) begin
            h++;
            if (h == H_TOT) begin
                h = 0;
                v++;
                if (v == V_TOT) v = 0;
            end
        end
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = (h < H_VIS) && (v < V_VIS);
        hsync      = (h >= 9) && (h < 11);
        vsync      = (v == 5);
        if (reset) src_rd = src_q.size();
        else if (acc_last && src_rd < src_q.size()) src_rd++;
        s_valid = !reset && src_en && (src_rd < src_q.size());
        cur     = s_valid ? src_q[src_rd] : 13'd0;
        s_sof   = cur[12];
        s_data  = cur[11:0];
    end

    // Reference model: the buffer is a plain queue; a frame is shown only when its
    // sof entry meets the top-left visible position, any mismatch blanks and re-seeks.
    logic [12:0] mq[$];
    int          mode = M_SEEK;
    logic [11:0] exp_rgb = '0;
    logic        exp_hs = 1'b0, exp_vs = 1'b0, exp_lock = 1'b0, exp_err = 1'b0;
    logic [15:0] exp_cnt = '0;
    bit          m_fs, m_take, m_pop;
    logic [12:0] m_head;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mode     = M_SEEK;
            exp_rgb  = '0;
            exp_hs   = 1'b0;
            exp_vs   = 1'b0;
            exp_lock = 1'b0;
            exp_err  = 1'b0;
            exp_cnt  = '0;
            acc_last = 1'b0;
        end else begin
            m_fs    = display_on && hpos == 10'd0 && vpos == 10'd0;
            m_take  = s_valid && (mq.size() < DEPTH);
            m_pop   = 1'b0;
            m_head  = (mq.size() > 0) ? mq[0] : 13'd0;
            exp_rgb = '0;
            exp_err = 1'b0;
            if (mode == M_SEEK) begin
                if (mq.size() > 0) begin
                    if (m_head[12]) mode = M_WAIT;
                    else            m_pop = 1'b1;
                end
            end else if (mode == M_WAIT) begin
                if (m_fs && mq.size() > 0) begin
                    m_pop   = 1'b1;
                    exp_rgb = m_head[11:0];
                    mode    = M_PLAY;
                end
            end else if (display_on) begin
                if (mq.size() == 0) begin
                    exp_err = 1'b1;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    mode = M_SEEK;
                end else if (m_head[12] != m_fs) begin
                    exp_err = 1'b1;
                    mode    = m_head[12] ? M_WAIT : M_SEEK;
                end else begin
                    m_pop   = 1'b1;
                    exp_rgb = m_head[11:0];
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_take) mq.push_back({s_sof, s_data});
            acc_last = m_take;
            exp_hs   = hsync;
            exp_vs   = vsync;
            exp_lock = (mode == M_PLAY);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("rgb", vga_rgb, exp_rgb);
            chk("hsync", vga_hsync, exp_hs);
            chk("vsync", vga_vsync, exp_vs);
            chk("locked", locked, exp_lock);
            chk("underflow_cnt", underflow_cnt, exp_cnt);
            chk("sof_err", sof_err, exp_err);
            chk("s_ready", s_ready, mq.size() < DEPTH);
            chk("level", dut.u_fifo.level_o, mq.size());
            if (sof_err) err_pulses++;
        end
    end

    task automatic push_frame(input int base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back({i == 0, 12'(base + i)});
    endtask

    // Stop at the rising edge where the beam input equals (x,y), then step past it
    task automatic wait_beam(input int x, input int y);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            if (hpos == 10'(x) && vpos == 10'(y)) hit = 1'b1;
        end
        #1;
        chk("beam_reached", hit, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", vga_rgb, 12'h000);
        chk("rst_hsync", vga_hsync, 1'b0);
        chk("rst_vsync", vga_vsync, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_cnt", underflow_cnt, 16'd0);
        chk("rst_sof_err", sof_err, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        #3 reset = 1'b0;
        #1 chk("ready_after_rst", s_ready, 1'b1);

        // Junk ahead of frame A, then A, B and a truncated D
        for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 12'(12'hEE0 + i)});
        push_frame(12'h100, 32);
        push_frame(12'h200, 32);
        push_frame(12'h400, 20);
        raster_en = 1'b1;

        wait_beam(0, 0);
        chk("a_first_px", vga_rgb, 12'h100);
        chk("a_locked", locked, 1'b1);
        wait_beam(3, 2);
        chk("a_px_3_2", vga_rgb, 12'h113);
        chk("a_no_err", err_pulses, 0);
        chk("a_cnt", underflow_cnt, 16'd0);
        wait_beam(0, 0);
        chk("b_first_px", vga_rgb, 12'h200);

        // D underflows at its 21st visible pixel
        wait_beam(0, 0);
        chk("d_first_px", vga_rgb, 12'h400);
        wait_beam(3, 2);
        chk("d_last_px", vga_rgb, 12'h413);
        wait_beam(4, 2);
        chk("uf_rgb", vga_rgb, 12'h000);
        chk("uf_pulse", sof_err, 1'b1);
        chk("uf_cnt", underflow_cnt, 16'd1);
        chk("uf_unlocked", locked, 1'b0);

        // E relocks, F is one pixel short, G follows intact
        push_frame(12'h500, 32);
        push_frame(12'h600, 31);
        push_frame(12'h700, 32);
        wait_beam(0, 0);
        chk("e_first_px", vga_rgb, 12'h500);
        chk("e_locked", locked, 1'b1);
        chk("e_err_pulses", err_pulses, 1);
        wait_beam(0, 0);
        chk("f_first_px", vga_rgb, 12'h600);
        wait_beam(7, 3);
        chk("short_rgb", vga_rgb, 12'h000);
        chk("short_pulse", sof_err, 1'b1);
        chk("short_unlocked", locked, 1'b0);
        wait_beam(0, 0);
        chk("g_first_px", vga_rgb, 12'h700);
        chk("g_locked", locked, 1'b1);
        wait_beam(1, 0);
        chk("g_second_px", vga_rgb, 12'h701);
        chk("g_err_pulses", err_pulses, 2);

        // Fill the FIFO while the beam is parked in vertical blanking
        push_frame(12'h800, 32);
        push_frame(12'h900, 32);
        wait_beam(0, 5);
        raster_en = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("full_ready", s_ready, 1'b0);
        chk("full_level", dut.u_fifo.level_o, 16);
        src_en    = 1'b0;
        raster_en = 1'b1;
        wait_beam(11, 0);
        chk("drained_level", dut.u_fifo.level_o, 8);
        src_en = 1'b1;
        wait_beam(5, 1);
        chk("pushpop_level", dut.u_fifo.level_o, 8);
        chk("h_px_5_1", vga_rgb, 12'h80D);

        // Asynchronous reset in the middle of a visible line
        wait_beam(0, 0);
        chk("i_first_px", vga_rgb, 12'h900);
        wait_beam(3, 1);
        chk("pre_rst_cnt", underflow_cnt, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_rgb", vga_rgb, 12'h000);
        chk("arst_hsync", vga_hsync, 1'b0);
        chk("arst_vsync", vga_vsync, 1'b0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_cnt", underflow_cnt, 16'd0);
        chk("arst_sof_err", sof_err, 1'b0);
        chk("arst_ready", s_ready, 1'b0);
        chk("arst_level", dut.u_fifo.level_o, 0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;
        push_frame(12'hA00, 32);
        push_frame(12'hB00, 32);
        wait_beam(0, 0);
        chk("j_first_px", vga_rgb, 12'hA00);
        chk("j_locked", locked, 1'b1);
        wait_beam(2, 3);
        chk("j_px_2_3", vga_rgb, 12'hA1A);
        chk("j_err_pulses", err_pulses, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
